// File: rtl/alu_operand_stage_pkg.sv
// ALU opsel encodings and default widths for the operand stage.
// Shared by the stage, its forwarding mux, its interface and benches.
package alu_operand_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned ADDR_W = 5;

  localparam logic [OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [OP_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'b0101;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'b0111;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode->EX bus: decoded operands, hazard inputs, ALU-facing outputs.
// slave: stage view (_i in, _o out); master: driver view.
interface alu_operand_stage_if
  import alu_operand_stage_pkg::*;
#(
  parameter int unsigned Data_Width     = DATA_W,
  parameter int unsigned Op_Width       = OP_W,
  parameter int unsigned Reg_Addr_Width = ADDR_W
) ();

  logic                      valid_i;
  logic [Reg_Addr_Width-1:0] rs1_addr_i;
  logic [Reg_Addr_Width-1:0] rs2_addr_i;
  logic [Data_Width-1:0]     rs1_data_i;
  logic [Data_Width-1:0]     rs2_data_i;
  logic [Data_Width-1:0]     pc_i;
  logic [Data_Width-1:0]     imm_i;
  logic                      sel_a_i;
  logic                      sel_b_i;
  logic [Op_Width-1:0]       opsel_i;
  logic [Reg_Addr_Width-1:0] rd_addr_i;
  logic                      reg_wr_i;
  logic                      stall_i;
  logic                      flush_i;
  logic [Data_Width-1:0]     ex_result_i;
  logic                      wb_wr_i;
  logic [Reg_Addr_Width-1:0] wb_rd_i;
  logic [Data_Width-1:0]     wb_data_i;
  logic                      valid_o;
  logic [Data_Width-1:0]     operand_a_o;
  logic [Data_Width-1:0]     operand_b_o;
  logic [Op_Width-1:0]       opsel_o;
  logic [Reg_Addr_Width-1:0] rd_addr_o;
  logic                      reg_wr_o;

  modport slave (
    input  valid_i, rs1_addr_i, rs2_addr_i,
    input  rs1_data_i, rs2_data_i, pc_i, imm_i,
    input  sel_a_i, sel_b_i, opsel_i,
    input  rd_addr_i, reg_wr_i,
    input  stall_i, flush_i, ex_result_i,
    input  wb_wr_i, wb_rd_i, wb_data_i,
    output valid_o, operand_a_o, operand_b_o,
    output opsel_o, rd_addr_o, reg_wr_o
  );

  modport master (
    output valid_i, rs1_addr_i, rs2_addr_i,
    output rs1_data_i, rs2_data_i, pc_i, imm_i,
    output sel_a_i, sel_b_i, opsel_i,
    output rd_addr_i, reg_wr_i,
    output stall_i, flush_i, ex_result_i,
    output wb_wr_i, wb_rd_i, wb_data_i,
    input  valid_o, operand_a_o, operand_b_o,
    input  opsel_o, rd_addr_o, reg_wr_o
  );

endinterface

// File: rtl/alu_operand_stage_fwd_mux.sv
// Per-source forwarding select: x0, then EX, then WB, then regfile.
// Ports: i_addr/i_rf_data source, i_ex_*/i_wb_* producers, o_data.
module operand_fwd_mux
  import alu_operand_stage_pkg::*;
#(
  parameter int unsigned Data_Width     = DATA_W,
  parameter int unsigned Reg_Addr_Width = ADDR_W
) (
  input  logic [Reg_Addr_Width-1:0] i_addr,
  input  logic [Data_Width-1:0]     i_rf_data,
  input  logic                      i_ex_wr,
  input  logic [Reg_Addr_Width-1:0] i_ex_rd,
  input  logic [Data_Width-1:0]     i_ex_data,
  input  logic                      i_wb_wr,
  input  logic [Reg_Addr_Width-1:0] i_wb_rd,
  input  logic [Data_Width-1:0]     i_wb_data,
  output logic [Data_Width-1:0]     o_data
);

  logic w_zero;
  logic w_ex_hit;
  logic w_wb_hit;

  assign w_zero   = (i_addr == '0);
  assign w_ex_hit = i_ex_wr & (i_ex_rd == i_addr);
  assign w_wb_hit = i_wb_wr & (i_wb_rd == i_addr);

  always_comb begin
    o_data = i_rf_data;
    if (w_zero)        o_data = '0;
    else if (w_ex_hit) o_data = i_ex_data;
    else if (w_wb_hit) o_data = i_wb_data;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register + operand select with EX/WB forwarding.
// Ports: clk_i, rst_ni (sync, active-low), bus (decode in, ALU out).
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int unsigned Data_Width     = DATA_W,
  parameter int unsigned Op_Width       = OP_W,
  parameter int unsigned Reg_Addr_Width = ADDR_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  alu_operand_stage_if.slave  bus
);

  logic                      r_valid;
  logic                      r_reg_wr;
  logic [Data_Width-1:0]     r_a;
  logic [Data_Width-1:0]     r_b;
  logic [Op_Width-1:0]       r_opsel;
  logic [Reg_Addr_Width-1:0] r_rd;
  logic [Reg_Addr_Width-1:0] r_rs1;
  logic [Reg_Addr_Width-1:0] r_rs2;
  logic                      r_sel_a;
  logic                      r_sel_b;

  logic [Data_Width-1:0]     w_fwd1;
  logic [Data_Width-1:0]     w_fwd2;
  logic                      w_ex_wr;
  logic                      w_ref_a;
  logic                      w_ref_b;

  // r_reg_wr is already qualified by r_valid
  assign w_ex_wr = r_valid & r_reg_wr;

  operand_fwd_mux #(
    .Data_Width     (Data_Width),
    .Reg_Addr_Width (Reg_Addr_Width)
  ) u_fwd1 (
    .i_addr    (bus.rs1_addr_i),
    .i_rf_data (bus.rs1_data_i),
    .i_ex_wr   (w_ex_wr),
    .i_ex_rd   (r_rd),
    .i_ex_data (bus.ex_result_i),
    .i_wb_wr   (bus.wb_wr_i),
    .i_wb_rd   (bus.wb_rd_i),
    .i_wb_data (bus.wb_data_i),
    .o_data    (w_fwd1)
  );

  operand_fwd_mux #(
    .Data_Width     (Data_Width),
    .Reg_Addr_Width (Reg_Addr_Width)
  ) u_fwd2 (
    .i_addr    (bus.rs2_addr_i),
    .i_rf_data (bus.rs2_data_i),
    .i_ex_wr   (w_ex_wr),
    .i_ex_rd   (r_rd),
    .i_ex_data (bus.ex_result_i),
    .i_wb_wr   (bus.wb_wr_i),
    .i_wb_rd   (bus.wb_rd_i),
    .i_wb_data (bus.wb_data_i),
    .o_data    (w_fwd2)
  );

  // A held register operand would miss a WB landing during the stall
  assign w_ref_a = ~r_sel_a & bus.wb_wr_i &
                   (bus.wb_rd_i == r_rs1) & (r_rs1 != '0);
  assign w_ref_b = ~r_sel_b & bus.wb_wr_i &
                   (bus.wb_rd_i == r_rs2) & (r_rs2 != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid  <= 1'b0;
      r_reg_wr <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_opsel  <= ALU_ADD;
      r_rd     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_sel_a  <= 1'b0;
      r_sel_b  <= 1'b0;
    end else if (bus.flush_i) begin
      r_valid  <= 1'b0;
      r_reg_wr <= 1'b0;
    end else if (bus.stall_i) begin
      if (w_ref_a) r_a <= bus.wb_data_i;
      if (w_ref_b) r_b <= bus.wb_data_i;
    end else begin
      r_valid  <= bus.valid_i;
      r_reg_wr <= bus.valid_i & bus.reg_wr_i;
      r_a      <= bus.sel_a_i ? bus.pc_i : w_fwd1;
      r_b      <= bus.sel_b_i ? bus.imm_i : w_fwd2;
      r_opsel  <= bus.opsel_i;
      r_rd     <= bus.rd_addr_i;
      r_rs1    <= bus.rs1_addr_i;
      r_rs2    <= bus.rs2_addr_i;
      r_sel_a  <= bus.sel_a_i;
      r_sel_b  <= bus.sel_b_i;
    end
  end

  assign bus.valid_o     = r_valid;
  assign bus.reg_wr_o    = r_reg_wr;
  assign bus.operand_a_o = r_a;
  assign bus.operand_b_o = r_b;
  assign bus.opsel_o     = r_opsel;
  assign bus.rd_addr_o   = r_rd;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, forwarding,
// x0, stall refresh, flush.
module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_operand_stage_if ifc ();

  alu_operand_stage dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (ifc.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ifc.valid_i     = 1'b0;
    ifc.rs1_addr_i  = '0;
    ifc.rs2_addr_i  = '0;
    ifc.rs1_data_i  = '0;
    ifc.rs2_data_i  = '0;
    ifc.pc_i        = '0;
    ifc.imm_i       = '0;
    ifc.sel_a_i     = 1'b0;
    ifc.sel_b_i     = 1'b0;
    ifc.opsel_i     = ALU_ADD;
    ifc.rd_addr_i   = '0;
    ifc.reg_wr_i    = 1'b0;
    ifc.stall_i     = 1'b0;
    ifc.flush_i     = 1'b0;
    ifc.ex_result_i = '0;
    ifc.wb_wr_i     = 1'b0;
    ifc.wb_rd_i     = '0;
    ifc.wb_data_i   = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(ifc.valid_o), 32'd0);
    chk({tag, "_regwr"}, 32'(ifc.reg_wr_o), 32'd0);
    chk({tag, "_opsel"}, 32'(ifc.opsel_o), 32'd0);
    chk({tag, "_rd"}, 32'(ifc.rd_addr_o), 32'd0);
    chk({tag, "_a"}, ifc.operand_a_o, 32'd0);
    chk({tag, "_b"}, ifc.operand_b_o, 32'd0);
  endtask

  initial begin
    idle();
    rst_ni = 1'b0;
    tick();
    chk_zero("rst0");
    rst_ni = 1'b1;

    // no hazard, imm on B
    ifc.valid_i    = 1'b1;
    ifc.rs1_addr_i = 5'd5;
    ifc.rs1_data_i = 32'd7;
    ifc.sel_b_i    = 1'b1;
    ifc.imm_i      = 32'hFFFF_FFFD;
    ifc.opsel_i    = ALU_ADD;
    ifc.rd_addr_i  = 5'd3;
    ifc.reg_wr_i   = 1'b1;
    tick();
    chk("nh_a", ifc.operand_a_o, 32'd7);
    chk("nh_b", ifc.operand_b_o, 32'hFFFF_FFFD);
    chk("nh_valid", 32'(ifc.valid_o), 32'd1);
    chk("nh_regwr", 32'(ifc.reg_wr_o), 32'd1);
    chk("nh_rd", 32'(ifc.rd_addr_o), 32'd3);

    // EX beats WB on rs1; rs2 from regfile
    ifc.ex_result_i = 32'd100;
    ifc.rs1_addr_i  = 5'd3;
    ifc.rs1_data_i  = 32'd1;
    ifc.wb_wr_i     = 1'b1;
    ifc.wb_rd_i     = 5'd3;
    ifc.wb_data_i   = 32'd50;
    ifc.sel_b_i     = 1'b0;
    ifc.rs2_addr_i  = 5'd6;
    ifc.rs2_data_i  = 32'h1234;
    ifc.opsel_i     = ALU_SUB;
    ifc.rd_addr_i   = 5'd0;
    tick();
    chk("ex_a", ifc.operand_a_o, 32'd100);
    chk("ex_b", ifc.operand_b_o, 32'h1234);
    chk("ex_opsel", 32'(ifc.opsel_o), 32'(ALU_SUB));

    // x0 never forwarded (held rd=0 wr=1, wb_rd=0)
    ifc.ex_result_i = 32'd9;
    ifc.wb_rd_i     = 5'd0;
    ifc.wb_data_i   = 32'd9;
    ifc.rs2_addr_i  = 5'd0;
    ifc.rs2_data_i  = 32'h55;
    ifc.rs1_addr_i  = 5'd7;
    ifc.rs1_data_i  = 32'h77;
    ifc.opsel_i     = ALU_AND;
    ifc.rd_addr_i   = 5'd4;
    tick();
    chk("x0_b", ifc.operand_b_o, 32'd0);
    chk("x0_a", ifc.operand_a_o, 32'h77);
    chk("x0_rd", 32'(ifc.rd_addr_o), 32'd4);

    // WB on rs1, EX on rs2; reg_wr_i=0
    ifc.ex_result_i = 32'hAAAA;
    ifc.rs1_addr_i  = 5'd8;
    ifc.rs1_data_i  = 32'd1;
    ifc.wb_rd_i     = 5'd8;
    ifc.wb_data_i   = 32'hBEEF;
    ifc.rs2_addr_i  = 5'd4;
    ifc.rs2_data_i  = 32'd2;
    ifc.rd_addr_i   = 5'd9;
    ifc.reg_wr_i    = 1'b0;
    ifc.opsel_i     = ALU_OR;
    tick();
    chk("wb_a", ifc.operand_a_o, 32'hBEEF);
    chk("wb_b", ifc.operand_b_o, 32'hAAAA);
    chk("wb_regwr", 32'(ifc.reg_wr_o), 32'd0);

    // stall refresh of register-sourced A
    ifc.wb_wr_i    = 1'b0;
    ifc.rs1_addr_i = 5'd4;
    ifc.rs1_data_i = 32'd11;
    ifc.sel_b_i    = 1'b1;
    ifc.imm_i      = 32'h100;
    ifc.opsel_i    = ALU_SLL;
    ifc.rd_addr_i  = 5'd10;
    ifc.reg_wr_i   = 1'b1;
    tick();
    chk("st_load_a", ifc.operand_a_o, 32'd11);
    ifc.stall_i     = 1'b1;
    ifc.valid_i     = 1'b0;
    ifc.rs1_data_i  = 32'd999;
    ifc.opsel_i     = ALU_SRA;
    ifc.ex_result_i = 32'd77;
    tick();
    chk("st1_a", ifc.operand_a_o, 32'd11);
    chk("st1_valid", 32'(ifc.valid_o), 32'd1);
    ifc.wb_wr_i   = 1'b1;
    ifc.wb_rd_i   = 5'd4;
    ifc.wb_data_i = 32'd22;
    tick();
    chk("st2_a", ifc.operand_a_o, 32'd22);
    chk("st2_b", ifc.operand_b_o, 32'h100);
    chk("st2_valid", 32'(ifc.valid_o), 32'd1);
    chk("st2_opsel", 32'(ifc.opsel_o), 32'(ALU_SLL));
    chk("st2_rd", 32'(ifc.rd_addr_o), 32'd10);

    // pc-sourced A is not refreshed
    ifc.stall_i = 1'b0;
    ifc.wb_wr_i = 1'b0;
    ifc.valid_i = 1'b1;
    ifc.sel_a_i = 1'b1;
    ifc.pc_i    = 32'h400;
    tick();
    chk("pc_a", ifc.operand_a_o, 32'h400);
    ifc.stall_i   = 1'b1;
    ifc.wb_wr_i   = 1'b1;
    ifc.wb_data_i = 32'd33;
    tick();
    chk("pc_st_a", ifc.operand_a_o, 32'h400);

    // flush beats stall
    ifc.flush_i = 1'b1;
    tick();
    chk("fl_valid", 32'(ifc.valid_o), 32'd0);
    chk("fl_regwr", 32'(ifc.reg_wr_o), 32'd0);

    // next load resumes
    idle();
    ifc.valid_i    = 1'b1;
    ifc.rs1_addr_i = 5'd2;
    ifc.rs1_data_i = 32'd5;
    ifc.sel_b_i    = 1'b1;
    ifc.imm_i      = 32'd8;
    ifc.opsel_i    = ALU_SUB;
    ifc.rd_addr_i  = 5'd6;
    ifc.reg_wr_i   = 1'b1;
    tick();
    chk("rs_valid", 32'(ifc.valid_o), 32'd1);
    chk("rs_a", ifc.operand_a_o, 32'd5);
    chk("rs_b", ifc.operand_b_o, 32'd8);
    chk("rs_regwr", 32'(ifc.reg_wr_o), 32'd1);
    chk("rs_rd", 32'(ifc.rd_addr_o), 32'd6);

    // reg_wr qualified by valid
    ifc.valid_i = 1'b0;
    tick();
    chk("iv_valid", 32'(ifc.valid_o), 32'd0);
    chk("iv_regwr", 32'(ifc.reg_wr_o), 32'd0);

    // mid-stream reset beats stall and a pending load
    ifc.valid_i = 1'b1;
    ifc.opsel_i = ALU_XOR;
    tick();
    chk("pre_valid", 32'(ifc.valid_o), 32'd1);
    ifc.stall_i = 1'b1;
    rst_ni      = 1'b0;
    tick();
    chk_zero("rst1");
    rst_ni = 1'b1;
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
